// File: rtl/spi_buf_loopback.sv
// spi_buf_loopback: command-decoding user side of spi_dev_core.
// Buffered write/read, live echo and status, one command per CSn frame.
module spi_buf_loopback #(
  parameter int unsigned AWIDTH    = 9,
  parameter logic [7:0]  IDLE_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] usr_mosi_data,
  input  logic       usr_mosi_stb,
  output logic [7:0] usr_miso_data,
  input  logic       usr_miso_ack,
  input  logic       csn_state,
  input  logic       csn_rise,
  input  logic       csn_fall
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] LEN_FULL = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] PTR_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_ECHO,
    S_STAT,
    S_IGNORE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]      r_mem [DEPTH];
  logic [7:0]      r_rd_data;
  logic [AWIDTH:0] r_wr_ptr;
  logic [AWIDTH:0] r_rd_ptr;
  logic [AWIDTH:0] r_len;
  logic            r_ovf;
  logic            r_udf;
  logic [1:0]      r_stat_idx;
  logic [7:0]      r_echo;
  logic [7:0]      r_miso;

  logic       w_desel;
  logic       w_fall;
  logic       w_stb;
  logic       w_ack;
  logic       w_cmd;
  logic       w_dec_wr;
  logic       w_dec_rd;
  logic       w_dec_echo;
  logic       w_dec_stat;
  logic       w_dec_bad;
  logic       w_wr_stb;
  logic       w_wr_room;
  logic       w_mem_we;
  logic       w_rd_ack;
  logic       w_rd_avail;
  logic       w_st_ack;
  logic       w_echo_stb;
  logic [15:0] w_len16;
  logic [7:0] w_stat_byte;
  logic [7:0] w_miso_nxt;

  // Deselect masks every strobe; the command byte is only the first stb in CMD
  assign w_desel    = csn_state | csn_rise;
  assign w_fall     = csn_fall & ~w_desel;
  assign w_stb      = usr_mosi_stb & ~w_desel;
  assign w_ack      = usr_miso_ack & ~w_desel;
  assign w_cmd      = (r_state == S_CMD) & w_stb & ~w_fall;
  assign w_dec_wr   = w_cmd & (usr_mosi_data == 8'h01);
  assign w_dec_rd   = w_cmd & (usr_mosi_data == 8'h02);
  assign w_dec_echo = w_cmd & (usr_mosi_data == 8'h03);
  assign w_dec_stat = w_cmd & (usr_mosi_data == 8'h04);
  assign w_dec_bad  = w_cmd & ~(w_dec_wr | w_dec_rd |
                                w_dec_echo | w_dec_stat);

  assign w_wr_stb   = (r_state == S_WRITE) & w_stb;
  assign w_wr_room  = r_wr_ptr < LEN_FULL;
  assign w_mem_we   = w_wr_stb & w_wr_room;
  assign w_rd_ack   = (r_state == S_READ) & w_ack;
  assign w_rd_avail = r_rd_ptr < r_len;
  assign w_st_ack   = (r_state == S_STAT) & w_ack;
  assign w_echo_stb = (r_state == S_ECHO) & w_stb;
  assign w_len16    = 16'(r_len);

  assign usr_miso_data = r_miso;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: deselect wins, then select, then command decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_desel:    w_state_nxt = S_IDLE;
      w_fall:     w_state_nxt = S_CMD;
      w_dec_wr:   w_state_nxt = S_WRITE;
      w_dec_rd:   w_state_nxt = S_READ;
      w_dec_echo: w_state_nxt = S_ECHO;
      w_dec_stat: w_state_nxt = S_STAT;
      w_dec_bad:  w_state_nxt = S_IGNORE;
      default:    ;
    endcase
  end

  // Buffer RAM: one write port, registered read port
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr[AWIDTH-1:0]] <= usr_mosi_data;
    r_rd_data <= r_mem[r_rd_ptr[AWIDTH-1:0]];
  end

  // Write pointer and length; length tracks pointer, full stops both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_len    <= '0;
    end else if (w_dec_wr) begin
      r_wr_ptr <= '0;
      r_len    <= '0;
    end else if (w_mem_we) begin
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_len    <= r_wr_ptr + PTR_ONE;
    end
  end

  // Sticky error flags, cleared only by a WRITE command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (w_dec_wr) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr_stb & ~w_wr_room)  r_ovf <= 1'b1;
      if (w_rd_ack & ~w_rd_avail) r_udf <= 1'b1;
    end
  end

  // Read pointer advances per ack while data remains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_rd_ptr <= '0;
    else if (w_dec_rd)               r_rd_ptr <= '0;
    else if (w_rd_ack & w_rd_avail)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
  end

  // Status index saturates on the trailing zero byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_stat_idx <= 2'd0;
    else if (w_dec_stat)                  r_stat_idx <= 2'd0;
    else if (w_st_ack && r_stat_idx != 2'd3)
      r_stat_idx <= r_stat_idx + 2'd1;
  end

  // Echo holds the last byte received in ECHO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_echo <= 8'h00;
    else if (w_dec_echo) r_echo <= 8'h00;
    else if (w_echo_stb) r_echo <= usr_mosi_data;
  end

  // MISO byte selection by phase
  always_comb begin
    w_stat_byte = 8'h00;
    unique case (r_stat_idx)
      2'd0:    w_stat_byte = w_len16[7:0];
      2'd1:    w_stat_byte = w_len16[15:8];
      2'd2:    w_stat_byte = {6'b0, r_udf, r_ovf};
      default: w_stat_byte = 8'h00;
    endcase
    w_miso_nxt = IDLE_BYTE;
    unique case (r_state)
      S_READ:   w_miso_nxt = w_rd_avail ? r_rd_data : 8'h00;
      S_ECHO:   w_miso_nxt = r_echo;
      S_STAT:   w_miso_nxt = w_stat_byte;
      S_IGNORE: w_miso_nxt = 8'hFF;
      default:  w_miso_nxt = IDLE_BYTE;
    endcase
  end

  // Registered MISO byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_miso <= IDLE_BYTE;
    else        r_miso <= w_miso_nxt;
  end

endmodule

// File: tb/tb_spi_buf_loopback.sv
// tb_spi_buf_loopback: frame-level bench for spi_buf_loopback.
// Emulates spi_dev_core strobes; checks MISO bytes per frame.
module tb_spi_buf_loopback;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] usr_mosi_data = 8'h00;
  logic       usr_mosi_stb = 1'b0;
  logic [7:0] usr_miso_data;
  logic       usr_miso_ack = 1'b0;
  logic       csn_state = 1'b1;
  logic       csn_rise = 1'b0;
  logic       csn_fall = 1'b0;

  always #5 clk = ~clk;

  spi_buf_loopback #(.AWIDTH(4), .IDLE_BYTE(8'hA5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .usr_mosi_data(usr_mosi_data),
    .usr_mosi_stb (usr_mosi_stb),
    .usr_miso_data(usr_miso_data),
    .usr_miso_ack (usr_miso_ack),
    .csn_state    (csn_state),
    .csn_rise     (csn_rise),
    .csn_fall     (csn_fall)
  );

  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][7:0] tx;
    logic [7:0][7:0] ex;
    logic [7:0]      chk;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] g_tx[$];
  logic [7:0] g_rx[$];
  int         g_exp[$];

  logic [7:0] m_mem [DEPTH];
  int         m_len = 0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic check_rx(input string nm, input int k,
                          input logic [7:0] exp);
    if (k >= g_rx.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: byte %0d missing, want %02h", nm, k, exp);
    end else begin
      check($sformatf("%s[%0d]", nm, k), g_rx[k], exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [63:0] txs,
                              input logic [63:0] exs,
                              input logic [7:0] chk);
    vec_t v;
    v.n   = 4'(n);
    v.chk = chk;
    for (int i = 0; i < 8; i++) begin
      v.tx[i] = txs[63-8*i -: 8];
      v.ex[i] = exs[63-8*i -: 8];
    end
    return v;
  endfunction

  task automatic start_frame();
    g_rx.delete();
    @(negedge clk);
    csn_state = 1'b0;
    csn_fall  = 1'b1;
    @(negedge clk);
    csn_fall = 1'b0;
    repeat (3) @(negedge clk);
    usr_miso_ack = 1'b1;
    g_rx.push_back(usr_miso_data);
    @(negedge clk);
    usr_miso_ack = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit ack,
                           input bit rise);
    repeat (8) @(negedge clk);
    usr_mosi_data = d;
    usr_mosi_stb  = 1'b1;
    if (rise) begin
      csn_rise  = 1'b1;
      csn_state = 1'b1;
    end
    if (ack) begin
      usr_miso_ack = 1'b1;
      g_rx.push_back(usr_miso_data);
    end
    @(negedge clk);
    usr_mosi_stb = 1'b0;
    usr_miso_ack = 1'b0;
    csn_rise     = 1'b0;
  endtask

  task automatic end_frame();
    repeat (3) @(negedge clk);
    csn_rise  = 1'b1;
    csn_state = 1'b1;
    @(negedge clk);
    csn_rise = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input bit cut);
    int n;
    n = g_tx.size();
    start_frame();
    for (int k = 0; k < n; k++)
      send_byte(g_tx[k], k < n - 1, cut && k == n - 1);
    if (cut) repeat (4) @(negedge clk);
    else end_frame();
  endtask

  // Byte-level reference: MISO byte k is latched at the ack that
  // coincides with the stb of byte k-1; -1 marks a don't-care byte.
  task automatic model_frame(input bit cut);
    int n;
    int nb;
    int rd;
    int idx;
    int e;
    n  = g_tx.size();
    nb = cut ? n - 1 : n;
    g_exp.delete();
    for (int k = 0; k < n; k++) g_exp.push_back(k < 2 ? 32'hA5 : -1);
    if (nb <= 0) return;
    case (g_tx[0])
      8'h01: begin
        m_len = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int i = 1; i < nb; i++) begin
          if (m_len < DEPTH) begin
            m_mem[m_len] = g_tx[i];
            m_len++;
          end else m_ovf = 1'b1;
        end
      end
      8'h02: begin
        rd = 0;
        for (int k = 2; k < n; k++) begin
          g_exp[k] = (rd < m_len) ? int'(m_mem[rd]) : 0;
          if (rd < m_len) rd++;
          else m_udf = 1'b1;
        end
      end
      8'h03: begin
        e = 0;
        for (int k = 2; k < n; k++) begin
          g_exp[k] = e;
          e = int'(g_tx[k-1]);
        end
      end
      8'h04: begin
        idx = 0;
        for (int k = 2; k < n; k++) begin
          case (idx)
            0:       g_exp[k] = m_len % 256;
            1:       g_exp[k] = m_len / 256;
            2:       g_exp[k] = 2 * int'(m_udf) + int'(m_ovf);
            default: g_exp[k] = 0;
          endcase
          if (idx < 3) idx++;
        end
      end
      default: for (int k = 2; k < n; k++) g_exp[k] = 32'hFF;
    endcase
  endtask

  task automatic load_stat();
    g_tx = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [9];
    tbl[0] = mk(4, 64'h01112233_00000000, 64'hA5A50000_00000000, 8'h03);
    tbl[1] = mk(5, 64'h02000000_00000000, 64'hA5A51122_33000000, 8'h1F);
    tbl[2] = mk(7, 64'h02000000_00000000, 64'hA5A51122_33000000, 8'h7F);
    tbl[3] = mk(5, 64'h04000000_00000000, 64'hA5A50300_02000000, 8'h1F);
    tbl[4] = mk(4, 64'h035AC37E_00000000, 64'hA5A5005A_00000000, 8'h0F);
    tbl[5] = mk(4, 64'h99010203_00000000, 64'hA5A5FFFF_00000000, 8'h0F);
    tbl[6] = mk(5, 64'h04000000_00000000, 64'hA5A50300_02000000, 8'h1F);
    tbl[7] = mk(2, 64'h01AA0000_00000000, 64'hA5A50000_00000000, 8'h03);
    tbl[8] = mk(5, 64'h04000000_00000000, 64'hA5A50100_00000000, 8'h1F);

    #12;
    check("reset_miso", usr_miso_data, 8'hA5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_miso", usr_miso_data, 8'hA5);

    for (int v = 0; v < 9; v++) begin
      g_tx.delete();
      for (int i = 0; i < int'(tbl[v].n); i++) g_tx.push_back(tbl[v].tx[i]);
      run_frame(1'b0);
      model_frame(1'b0);
      for (int k = 0; k < int'(tbl[v].n); k++)
        if (tbl[v].chk[k]) check_rx($sformatf("tbl%0d", v), k, tbl[v].ex[k]);
      check($sformatf("tbl%0d_idle", v), usr_miso_data, 8'hA5);
    end

    g_tx.delete();
    g_tx.push_back(8'h01);
    for (int i = 0; i < 20; i++) g_tx.push_back(8'(i));
    run_frame(1'b0);
    model_frame(1'b0);
    g_tx.delete();
    for (int i = 0; i < 19; i++) g_tx.push_back(i == 0 ? 8'h02 : 8'h00);
    run_frame(1'b0);
    model_frame(1'b0);
    for (int i = 0; i < 16; i++) check_rx("ovf_rd", 2 + i, 8'(i));
    check_rx("ovf_rd_end", 18, 8'h00);
    load_stat();
    run_frame(1'b0);
    model_frame(1'b0);
    check_rx("ovf_len", 2, 8'h10);
    check_rx("ovf_lenhi", 3, 8'h00);
    check_rx("ovf_flags", 4, 8'h03);

    g_tx = '{8'h01, 8'h11, 8'h22};
    run_frame(1'b1);
    model_frame(1'b1);
    load_stat();
    run_frame(1'b0);
    model_frame(1'b0);
    check_rx("cut_len", 2, 8'h01);
    check_rx("cut_flags", 4, 8'h00);
    g_tx = '{8'h02, 8'h00, 8'h00, 8'h00};
    run_frame(1'b0);
    model_frame(1'b0);
    check_rx("cut_rd", 2, 8'h11);
    check_rx("cut_rd_end", 3, 8'h00);

    start_frame();
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h44, 1'b1, 1'b0);
    send_byte(8'h55, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", usr_miso_data, 8'hA5);
    csn_state = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_len = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    load_stat();
    run_frame(1'b0);
    model_frame(1'b0);
    check_rx("rst_stat", 0, 8'hA5);
    check_rx("rst_stat", 1, 8'hA5);
    check_rx("rst_len", 2, 8'h00);
    check_rx("rst_lenhi", 3, 8'h00);
    check_rx("rst_flags", 4, 8'h00);

    for (int f = 0; f < 40; f++) begin
      int n;
      int c;
      n = $urandom_range(1, 22);
      c = $urandom_range(0, 4);
      g_tx.delete();
      g_tx.push_back(c == 4 ? 8'($urandom) : 8'(c + 1));
      for (int i = 1; i < n; i++) g_tx.push_back(8'($urandom));
      run_frame(1'b0);
      model_frame(1'b0);
      for (int k = 0; k < n; k++)
        if (g_exp[k] >= 0)
          check_rx($sformatf("rand%0d_c%02h", f, g_tx[0]), k, 8'(g_exp[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
